quant_align: RTL and testbench
==============================

# quant_align

Multi-lane successor to the single-lane FP32 pre-quantiser. It converts `LANES` FP32 activations per transaction into unsigned fixed-point magnitudes aligned to the exponent of a shared FP32 `i_max`. It sits between the activation buffer and the integer quantiser, behind a valid/ready handshake. Over the original it adds:
- parametrised output width and shift window;
- sign, zero, denormal and NaN/Inf handling;
- wrap-free exponent compare;
- pipelining with backpressure;
- a saturation statistics counter.

## Interface
- `LANES`, 4: activations per transaction.
- `OUT_W`, 32: output magnitude width per lane; legal range 8..(24+`MAX_SHIFT`).
- `MAX_SHIFT`, 8: largest exponent gap that still yields a non-zero result.
- `clk` input 1: the single clock.
- `reset` input 1: asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `i_valid` input 1: input transaction valid.
- `o_ready` output 1: block accepts input this cycle.
- `i_max` input 32: FP32 reference maximum for the transaction.
- `i_act` input LANES*32: FP32 activations; lane k is bits [32k+31:32k].
- `o_valid` output 1: output transaction valid.
- `i_ready` input 1: downstream accepts output.
- `o_unit` output 32: unit word `{2'b01, i_max[22:0], 7'd0}` of the same transaction.
- `o_act` output LANES*OUT_W: aligned magnitudes; lane k is bits [OUT_W*k+OUT_W-1:OUT_W*k].
- `o_sign` output LANES: lane sign bit (`i_act` bit 31).
- `o_sat` output LANES: lane saturated.
- `i_clear` input 1: synchronous clear of `o_sat_cnt`.
- `o_sat_cnt` output 16: count of saturated lanes; sticks at 0xFFFF.

## Operation
- Per lane, with `ea` = activation exponent, `em` = `i_max` exponent, and `d` = `em` − `ea` computed as a 9-bit signed value (no wrap when `em` < `MAX_SHIFT`):
  - `ea` == 255 (Inf/NaN) or `d` < 0: `o_act` = all ones, `o_sat` = 1.
  - `ea` == 0 (zero/denormal) or `d` > `MAX_SHIFT`: `o_act` = 0, `o_sat` = 0.
  - Otherwise: form field F = `{1'b1, mant[22:0], MAX_SHIFT zeros}` (24+`MAX_SHIFT` bits), F >>= `d`, and take `o_act` = top `OUT_W` bits of F. `o_sat` = 0.
- `o_sign` is passed through for all classes. `o_act` is always the magnitude only.
- `o_unit` depends only on `i_max`. It no longer varies with the activation class.
- `o_sat_cnt` adds popcount(`o_sat`) on each output handshake (`o_valid` && `i_ready`) and saturates at 0xFFFF.
  - `i_clear` zeroes the counter. When `i_clear` coincides with a handshake, the clear wins and that handshake's count is dropped.

## Timing
- Two-stage pipeline:
  - S1 registers the class, `d`, sign, mantissa and `i_max` fields.
  - S2 registers the shifted result. S2 is the output register.
- Latency is 2 cycles from the input handshake to `o_valid`. Throughput is 1 transaction per cycle while `i_ready` = 1.
- Global advance enable `en` = !`o_valid` || `i_ready`. `o_ready` = `en`. Both stages advance only when `en` = 1.
- While stalled, all outputs hold stable. Transactions are never dropped, duplicated or reordered.
- Bubbles propagate as invalid stages. `o_valid` must not depend combinationally on `i_ready`.
- Reset values: `o_valid` = 0, `o_act` = 0, `o_unit` = 0, `o_sign` = 0, `o_sat` = 0, `o_sat_cnt` = 0. `o_ready` = 1 once reset is released.
- Reset asserted mid-stream discards all in-flight transactions immediately.

## Configuration
- `QUANT_ALIGN_ROUND_EN` defined:
  - The bits of F below the `OUT_W` window are rounded half-up into `o_act`.
  - A carry out of `OUT_W` bits forces `o_act` to all ones and sets `o_sat` = 1.
  - Rounding is done in S2; latency is unchanged.
- `QUANT_ALIGN_ROUND_EN` undefined: those bits are truncated.
- When `OUT_W` = 24+`MAX_SHIFT`, the two modes are identical.

## Structure
- Package `quant_pkg` holds:
  - FP32 field constants (`EXP_MSB`, `EXP_LSB`, `MANT_W` = 23, `EXP_INF` = 255);
  - the lane class enum (`CLS_NORM`, `CLS_SAT`, `CLS_ZERO`);
  - the `UNIT_PAD` = 7 constant.
- Sub-module `quant_align_lane` holds one lane's S1 classify and S2 shift/round, instantiated `LANES` times.
- The top level owns the handshake, `i_max`/`o_unit` staging and `o_sat_cnt`.

## Test plan
All scenarios use defaults (`LANES` = 4, `OUT_W` = 32, `MAX_SHIFT` = 8) unless stated.
- Lane0 `i_max` = 0x40000000, `i_act` = 0x40000000 → `o_act` = 0x80000000, `o_unit` = 0x40000000, `o_sat` = 0, arriving 2 cycles after accept.
- Lanes = 0x3C000000 (`d` = 8), 0x3B800000 (`d` = 9), 0x40800000 (`d` = −1), 0xC0000000 → `o_act` = 0x00800000, 0, 0xFFFFFFFF, 0x80000000; `o_sat` = 0b0100; `o_sign` = 0b1000; `o_sat_cnt` = 1.
- `i_max` = 0x03000000, act = 0x00800000 (`d` = 5, no wrap) → 0x04000000. Act = 0x00000001 (denormal) → 0. Act = 0x7FC00000 (NaN) → 0xFFFFFFFF with `o_sat` = 1.
- Send 5 back-to-back transactions with `i_ready` low for 3 cycles mid-stream → all 5 are received in order, outputs stay stable during the stall, and `o_ready` = 0 while the pipeline is full and stalled.
- With `QUANT_ALIGN_ROUND_EN`, `OUT_W` = 16, `i_max` = 0x40000000, act = 0x3C7FFFFF → `o_act` = 0x0100; without the macro → 0x00FF.
- Reset asserted during the 3rd of 4 streamed transactions, plus `i_clear` coinciding with a saturating handshake → `o_valid` = 0 and `o_sat_cnt` = 0 immediately; no stale output after reset is released.

Source files
------------

// File: rtl/quant_pkg.sv
// Shared FP32 field constants, lane classification and unit-word padding
// for the quant_align activation pre-quantiser.
package quant_pkg;

    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MANT_W   = 23;
    localparam int UNIT_PAD = 7;
    localparam logic [EXP_MSB-EXP_LSB:0] EXP_INF = 8'd255;

    typedef enum logic [1:0] {
        CLS_NORM,
        CLS_SAT,
        CLS_ZERO
    } lane_cls_t;

endpackage

// File: rtl/quant_align_lane.sv
// One lane of quant_align: S1 classifies the activation against the shared
// exponent, S2 shifts it into the output window. QUANT_ALIGN_ROUND_EN rounds half-up.
module quant_align_lane
    import quant_pkg::*;
#(
    parameter int OUT_W     = 32,
    parameter int MAX_SHIFT = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic [31:0]                act,
    input  logic [EXP_MSB-EXP_LSB:0]   exp_max,
    output logic [OUT_W-1:0]           mag,
    output logic                       sign,
    output logic                       sat
);
    localparam int F_W  = MANT_W + 1 + MAX_SHIFT;
    localparam int SH_W = $clog2(MAX_SHIFT + 1);

    logic [EXP_MSB-EXP_LSB:0] exp_act;
    logic signed [8:0]        gap;
    lane_cls_t                cls_d;
    lane_cls_t                cls_q;
    logic [SH_W-1:0]          shift_q;
    logic [MANT_W-1:0]        mant_q;
    logic                     sign_q;
    logic [F_W-1:0]           field;
    logic [OUT_W-1:0]         top;
    logic [OUT_W-1:0]         mag_d;
    logic                     sat_d;

    // Nine-bit signed gap keeps small shared exponents from wrapping.
    assign exp_act = act[EXP_MSB:EXP_LSB];
    assign gap     = $signed({1'b0, exp_max}) - $signed({1'b0, exp_act});

    always_comb begin
        cls_d = CLS_NORM;
        if (exp_act == EXP_INF || gap[8]) begin
            cls_d = CLS_SAT;
        end else if (exp_act == '0 || gap[7:0] > 8'(MAX_SHIFT)) begin
            cls_d = CLS_ZERO;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cls_q   <= CLS_ZERO;
            shift_q <= '0;
            mant_q  <= '0;
            sign_q  <= 1'b0;
        end else if (en) begin
            cls_q   <= cls_d;
            shift_q <= gap[SH_W-1:0];
            mant_q  <= act[MANT_W-1:0];
            sign_q  <= act[31];
        end
    end

    assign field = {1'b1, mant_q, {MAX_SHIFT{1'b0}}} >> shift_q;
    assign top   = OUT_W'(field >> (F_W - OUT_W));

`ifdef QUANT_ALIGN_ROUND_EN
    logic             round_bit;
    logic [OUT_W:0]   rounded;

    generate
        if (OUT_W < F_W) begin : g_round
            assign round_bit = field[F_W-OUT_W-1];
        end else begin : g_exact
            assign round_bit = 1'b0;
        end
    endgenerate

    assign rounded = {1'b0, top} + {{OUT_W{1'b0}}, round_bit};
`endif

    always_comb begin
        mag_d = '0;
        sat_d = 1'b0;
        case (cls_q)
            CLS_SAT: begin
                mag_d = '1;
                sat_d = 1'b1;
            end
            CLS_NORM: begin
`ifdef QUANT_ALIGN_ROUND_EN
                if (rounded[OUT_W]) begin
                    mag_d = '1;
                    sat_d = 1'b1;
                end else begin
                    mag_d = rounded[OUT_W-1:0];
                end
`else
                mag_d = top;
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mag  <= '0;
            sign <= 1'b0;
            sat  <= 1'b0;
        end else if (en) begin
            mag  <= mag_d;
            sign <= sign_q;
            sat  <= sat_d;
        end
    end

endmodule

// File: rtl/quant_align.sv
// Multi-lane FP32 pre-quantiser: two-stage aligned-magnitude pipeline with
// valid/ready backpressure and a saturation counter. Option: QUANT_ALIGN_ROUND_EN.
module quant_align
    import quant_pkg::*;
#(
    parameter int LANES     = 4,
    parameter int OUT_W     = 32,
    parameter int MAX_SHIFT = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [31:0]            i_max,
    input  logic [LANES*32-1:0]    i_act,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [31:0]            o_unit,
    output logic [LANES*OUT_W-1:0] o_act,
    output logic [LANES-1:0]       o_sign,
    output logic [LANES-1:0]       o_sat,
    input  logic                   i_clear,
    output logic [15:0]            o_sat_cnt
);
    logic              en;
    logic              valid_s1;
    logic [MANT_W-1:0] max_mant_s1;
    logic              unused_max_sign;
    logic [15:0]       sat_pop;
    logic [16:0]       cnt_sum;

    // A single enable stalls the whole pipe, so o_valid never sees i_ready combinationally.
    assign en              = !o_valid || i_ready;
    assign o_ready         = en;
    assign unused_max_sign = i_max[31];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_s1    <= 1'b0;
            o_valid     <= 1'b0;
            max_mant_s1 <= '0;
            o_unit      <= '0;
        end else if (en) begin
            valid_s1    <= i_valid;
            o_valid     <= valid_s1;
            max_mant_s1 <= i_max[MANT_W-1:0];
            o_unit      <= {2'b01, max_mant_s1, {UNIT_PAD{1'b0}}};
        end
    end

    generate
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            quant_align_lane #(
                .OUT_W     (OUT_W),
                .MAX_SHIFT (MAX_SHIFT)
            ) u_lane (
                .clk     (clk),
                .reset   (reset),
                .en      (en),
                .act     (i_act[32*k +: 32]),
                .exp_max (i_max[EXP_MSB:EXP_LSB]),
                .mag     (o_act[OUT_W*k +: OUT_W]),
                .sign    (o_sign[k]),
                .sat     (o_sat[k])
            );
        end
    endgenerate

    always_comb begin
        sat_pop = '0;
        for (int k = 0; k < LANES; k++) begin
            sat_pop = sat_pop + 16'(o_sat[k]);
        end
    end

    assign cnt_sum = {1'b0, o_sat_cnt} + {1'b0, sat_pop};

    // Clear takes priority over a coincident handshake; the count sticks at all ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_sat_cnt <= '0;
        end else if (i_clear) begin
            o_sat_cnt <= '0;
        end else if (o_valid && i_ready) begin
            o_sat_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
        end
    end

endmodule

// File: tb/tb_quant_align.sv
// Self-checking bench for quant_align: directed cases plus randomized traffic
// scored against a arithmetic reference model, on 32-bit and 16-bit output builds.
module tb_quant_align;

    localparam int MS = 8;

    typedef struct {
        logic [127:0] act;
        logic [31:0]  max;
        int           cyc;
    } txn_t;

    logic         clk;
    logic         reset;
    logic         i_valid;
    logic         i_ready;
    logic         i_clear;
    logic [31:0]  i_max;
    logic [127:0] i_act;

    logic         o_ready,   o_ready16;
    logic         o_valid,   o_valid16;
    logic [31:0]  o_unit,    o_unit16;
    logic [127:0] o_act;
    logic [63:0]  o_act16;
    logic [3:0]   o_sign,    o_sign16;
    logic [3:0]   o_sat,     o_sat16;
    logic [15:0]  o_sat_cnt, o_sat_cnt16;

    int   checks;
    int   failures;
    int   cyc;
    int   exp_cnt;
    int   exp_cnt16;
    bit   lat_check;
    bit   rand_done;
    txn_t sb[$];

    quant_align #(.LANES(4), .OUT_W(32), .MAX_SHIFT(MS)) dut (
        .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(o_ready),
        .i_max(i_max), .i_act(i_act), .o_valid(o_valid), .i_ready(i_ready),
        .o_unit(o_unit), .o_act(o_act), .o_sign(o_sign), .o_sat(o_sat),
        .i_clear(i_clear), .o_sat_cnt(o_sat_cnt)
    );

    quant_align #(.LANES(4), .OUT_W(16), .MAX_SHIFT(MS)) dut16 (
        .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(o_ready16),
        .i_max(i_max), .i_act(i_act), .o_valid(o_valid16), .i_ready(i_ready),
        .o_unit(o_unit16), .o_act(o_act16), .o_sign(o_sign16), .o_sat(o_sat16),
        .i_clear(i_clear), .o_sat_cnt(o_sat_cnt16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    // Reference: value of the activation in units of 2^(em-23-MS), floored/rounded to w bits.
    function automatic void refLane(input logic [31:0] a, input logic [31:0] m, input int w,
                                    output logic [31:0] mag, output logic sat);
        int     ea, em, d, drop;
        longint f, q, lim;
        ea  = int'(a[30:23]);
        em  = int'(m[30:23]);
        d   = em - ea;
        lim = (longint'(1) << w) - 1;
        mag = '0;
        sat = 1'b0;
        if (ea == 255 || d < 0) begin
            mag = 32'(lim);
            sat = 1'b1;
        end else if (ea != 0 && d <= MS) begin
            f    = ((longint'(a[22:0]) + (longint'(1) << 23)) << MS) >> d;
            drop = 24 + MS - w;
            q    = f >> drop;
`ifdef QUANT_ALIGN_ROUND_EN
            if (drop > 0 && ((f >> (drop - 1)) & 1) == 1) q = q + 1;
`endif
            if (q > lim) begin
                mag = 32'(lim);
                sat = 1'b1;
            end else begin
                mag = 32'(q);
            end
        end
    endfunction

    function automatic logic [127:0] pad16(input logic [63:0] v);
        logic [127:0] r;
        for (int k = 0; k < 4; k++) r[32*k +: 32] = {16'h0, v[16*k +: 16]};
        return r;
    endfunction

    task automatic checkTxn(input string tag, input txn_t t, input int w, input logic [127:0] act_obs,
                            input logic [3:0] sign_obs, input logic [3:0] sat_obs,
                            input logic [31:0] unit_obs, output int pop);
        logic [31:0] m;
        logic        s;
        logic [3:0]  es;
        pop = 0;
        es  = '0;
        for (int k = 0; k < 4; k++) begin
            refLane(t.act[32*k +: 32], t.max, w, m, s);
            checkOutput($sformatf("%s_act%0d", tag, k), act_obs[32*k +: 32], m);
            es[k] = s;
            if (s) pop++;
        end
        checkOutput({tag, "_sat"}, 32'(sat_obs), 32'(es));
        checkOutput({tag, "_sign"}, 32'(sign_obs), {28'h0, t.act[127], t.act[95], t.act[63], t.act[31]});
        checkOutput({tag, "_unit"}, unit_obs, {2'b01, t.max[22:0], 7'd0});
    endtask

    // Scoreboard: outputs are checked against the oldest accepted transaction every valid cycle.
    always @(negedge clk) begin
        int pop, pop16;
        if (reset) begin
            sb.delete();
            exp_cnt   = 0;
            exp_cnt16 = 0;
        end else begin
            pop   = 0;
            pop16 = 0;
            checkOutput("sat_cnt", 32'(o_sat_cnt), exp_cnt);
            checkOutput("sat_cnt16", 32'(o_sat_cnt16), exp_cnt16);
            checkOutput("o_ready", 32'(o_ready), 32'(!o_valid || i_ready));
            checkOutput("o_ready16", 32'(o_ready16), 32'(!o_valid16 || i_ready));
            if (o_valid || o_valid16) begin
                if (sb.size() == 0) begin
                    checkOutput("spurious_valid", 32'({o_valid, o_valid16}), 0);
                end else begin
                    checkTxn("w32", sb[0], 32, o_act, o_sign, o_sat, o_unit, pop);
                    checkTxn("w16", sb[0], 16, pad16(o_act16), o_sign16, o_sat16, o_unit16, pop16);
                    checkOutput("valid32", 32'(o_valid), 1);
                    checkOutput("valid16", 32'(o_valid16), 1);
                    if (lat_check && i_ready) checkOutput("latency", cyc - sb[0].cyc, 2);
                    if (i_ready) void'(sb.pop_front());
                end
            end
            if (i_clear) begin
                exp_cnt   = 0;
                exp_cnt16 = 0;
            end else if (o_valid && i_ready) begin
                exp_cnt   = (exp_cnt + pop > 65535) ? 65535 : exp_cnt + pop;
                exp_cnt16 = (exp_cnt16 + pop16 > 65535) ? 65535 : exp_cnt16 + pop16;
            end
            if (i_valid && o_ready) sb.push_back('{i_act, i_max, cyc});
        end
    end

    task automatic applyStimulus(input logic [127:0] a, input logic [31:0] m);
        logic took;
        took    = 1'b0;
        i_act   = a;
        i_max   = m;
        i_valid = 1'b1;
        for (int n = 0; n < 200 && !took; n++) begin
            @(negedge clk);
            took = o_ready;
            @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
        if (!took) checkOutput("accept_timeout", 0, 1);
    endtask

    task automatic waitDrain();
        for (int n = 0; n < 500 && sb.size() != 0; n++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("drain", sb.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] randAct(input logic [7:0] em);
        logic [31:0] a;
        int          r, e;
        a = $urandom;
        r = int'($urandom_range(0, 15));
        if (r == 0) begin
            e = 0;
            if (a[0]) a[22:0] = '0;
        end else if (r == 1) begin
            e = 255;
        end else begin
            e = int'(em) + 2 - int'($urandom_range(0, 12));
            if (e < 1) e = 1;
            if (e > 254) e = 254;
        end
        a[30:23] = e[7:0];
        return a;
    endfunction

    task automatic sendRandom(input int count);
        logic [31:0]  m;
        logic [127:0] a;
        for (int n = 0; n < count; n++) begin
            m = $urandom;
            m[30:23] = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 9)) : 8'($urandom_range(1, 254));
            for (int k = 0; k < 4; k++) a[32*k +: 32] = randAct(m[30:23]);
            applyStimulus(a, m);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        rand_done = 1'b1;
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        checks = 0; failures = 0; cyc = 0; exp_cnt = 0; exp_cnt16 = 0;
        lat_check = 1'b1; rand_done = 1'b0;
        reset = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_clear = 1'b0;
        i_max = '0; i_act = '0;

        #12;
        checkOutput("rst_valid", 32'(o_valid), 0);
        checkOutput("rst_act0", o_act[31:0], 0);
        checkOutput("rst_act3", o_act[127:96], 0);
        checkOutput("rst_unit", o_unit, 0);
        checkOutput("rst_sign_sat", {24'h0, o_sign, o_sat}, 0);
        checkOutput("rst_cnt", 32'(o_sat_cnt), 0);
        @(posedge clk);
        #3 reset = 1'b0;
        #1 checkOutput("rst_ready", 32'(o_ready), 1);
        @(posedge clk);
        #1;

        $display("[TB] directed: single lane and latency");
        applyStimulus({96'h0, 32'h40000000}, 32'h40000000);
        checkOutput("t1_early_valid", 32'(o_valid), 0);
        @(posedge clk);
        #1;
        checkOutput("t1_valid", 32'(o_valid), 1);
        checkOutput("t1_act0", o_act[31:0], 32'h80000000);
        checkOutput("t1_unit", o_unit, 32'h40000000);
        checkOutput("t1_sat", 32'(o_sat), 0);

        $display("[TB] directed: lane classes");
        applyStimulus({32'hC0000000, 32'h40800000, 32'h3B800000, 32'h3C000000}, 32'h40000000);
        @(posedge clk);
        #1;
        checkOutput("t2_act0", o_act[31:0], 32'h00800000);
        checkOutput("t2_act1", o_act[63:32], 32'h0);
        checkOutput("t2_act2", o_act[95:64], 32'hFFFFFFFF);
        checkOutput("t2_act3", o_act[127:96], 32'h80000000);
        checkOutput("t2_sat", 32'(o_sat), 32'h4);
        checkOutput("t2_sign", 32'(o_sign), 32'h8);
        @(posedge clk);
        #1;
        checkOutput("t2_cnt", 32'(o_sat_cnt), 1);

        $display("[TB] directed: small exponent, denormal, NaN");
        applyStimulus({32'h0, 32'h7FC00000, 32'h00000001, 32'h00800000}, 32'h03000000);
        @(posedge clk);
        #1;
        checkOutput("t3_act0", o_act[31:0], 32'h04000000);
        checkOutput("t3_act1", o_act[63:32], 32'h0);
        checkOutput("t3_act2", o_act[95:64], 32'hFFFFFFFF);
        checkOutput("t3_sat", 32'(o_sat), 32'h4);

        $display("[TB] directed: 16-bit window rounding");
        applyStimulus({96'h0, 32'h3C7FFFFF}, 32'h40000000);
        @(posedge clk);
        #1;
        checkOutput("t4_act32", o_act[31:0], 32'h00FFFFFF);
`ifdef QUANT_ALIGN_ROUND_EN
        checkOutput("t4_act16", 32'(o_act16[15:0]), 32'h0100);
`else
        checkOutput("t4_act16", 32'(o_act16[15:0]), 32'h00FF);
`endif
        waitDrain();

        $display("[TB] directed: reset mid-stream");
        fork
            for (int n = 0; n < 4; n++)
                applyStimulus({32'h0, 32'h7F800000, 32'h3F800000 + 32'(n), 32'h40000000}, 32'h40000000);
            begin
                repeat (2) @(posedge clk);
                #2 reset = 1'b1;
                #1;
                checkOutput("mid_rst_valid", 32'(o_valid), 0);
                checkOutput("mid_rst_cnt", 32'(o_sat_cnt), 0);
                checkOutput("mid_rst_act2", o_act[95:64], 0);
                @(posedge clk);
                #3 reset = 1'b0;
                #1;
                checkOutput("post_rst_ready", 32'(o_ready), 1);
                checkOutput("post_rst_valid", 32'(o_valid), 0);
            end
        join
        waitDrain();

        $display("[TB] directed: back-to-back with stall");
        lat_check = 1'b0;
        fork
            for (int n = 0; n < 5; n++)
                applyStimulus({32'h3F000000 + 32'(n), 32'hBF800000, 32'h40800000, 32'h3E000000 + 32'(n << 20)},
                              32'h40000000);
            begin
                repeat (3) @(posedge clk);
                #1 i_ready = 1'b0;
                @(negedge clk);
                checkOutput("stall_valid", 32'(o_valid), 1);
                checkOutput("stall_ready", 32'(o_ready), 0);
                repeat (3) @(posedge clk);
                #1 i_ready = 1'b1;
            end
        join
        waitDrain();

        $display("[TB] random traffic with backpressure and clears");
        rand_done = 1'b0;
        fork
            sendRandom(150);
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    i_ready = ($urandom_range(0, 3) != 0);
                    i_clear = ($urandom_range(0, 15) == 0);
                end
                i_ready = 1'b1;
                i_clear = 1'b0;
            end
        join
        waitDrain();
        lat_check = 1'b1;

        $display("[TB] counter stick at all ones");
        for (int n = 0; n < 16400; n++)
            applyStimulus({4{32'h7FC00000}}, 32'h40000000);
        waitDrain();
        checkOutput("cnt_stick", 32'(o_sat_cnt), 32'hFFFF);

        $display("[TB] clear coinciding with saturating handshake");
        applyStimulus({4{32'hFF800000}}, 32'h40000000);
        @(posedge clk);
        #1;
        checkOutput("clr_valid", 32'(o_valid), 1);
        i_clear = 1'b1;
        @(posedge clk);
        #1;
        i_clear = 1'b0;
        checkOutput("clr_cnt", 32'(o_sat_cnt), 0);
        waitDrain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
